// File: rtl/result_router.sv
// Routes 36-bit read results to four per-ID FIFO channels and flags dropped results.
// Define RESULT_ROUTER_DROP_CNT_EN to build the saturating drop_cnt counter.

module result_router_chan #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] data_in,
    input  logic        ack,
    output logic [31:0] data_out,
    output logic        done,
    output logic        blocked
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0] count;
    logic          pop;

    assign done    = (count != '0);
    assign pop     = ack & done;
    // A full buffer still accepts a push when the same edge pops.
    assign blocked = (count == CW'(DEPTH)) & ~pop;
    assign rd_nxt  = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            data_out <= 32'h0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_nxt;
            count <= count + CW'(push) - CW'(pop);
            // data_out is a registered copy of the head; it holds when the buffer drains.
            if (pop) begin
                if (count > CW'(1))
                    data_out <= mem[rd_nxt];
                else if (push)
                    data_out <= data_in;
            end else if (push && count == '0) begin
                data_out <= data_in;
            end
        end
    end
endmodule

module result_router #(
    parameter int BASE_ID = 1,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        result_valid,
    input  logic [35:0] result,
    output logic [31:0] data_out_1,
    output logic [31:0] data_out_2,
    output logic [31:0] data_out_3,
    output logic [31:0] data_out_4,
    output logic        done_1,
    output logic        done_2,
    output logic        done_3,
    output logic        done_4,
    input  logic        ack_1,
    input  logic        ack_2,
    input  logic        ack_3,
    input  logic        ack_4,
    output logic        err,
    output logic [7:0]  drop_cnt
);
    localparam int NCH = 4;

    logic [4:0]            offset;
    logic                  in_range;
    logic [1:0]            sel;
    logic                  drop;
    logic [NCH-1:0]        ack, done, blocked, push;
    logic [NCH-1:0][31:0]  dout;

    // IDs below BASE_ID wrap to a large offset and fall out of range.
    assign offset   = {1'b0, result[35:32]} - 5'(BASE_ID);
    assign in_range = (offset < 5'd4);
    assign sel      = offset[1:0];
    assign drop     = result_valid & (~in_range | blocked[sel]);

    assign ack = {ack_4, ack_3, ack_2, ack_1};
    assign {done_4, done_3, done_2, done_1} = done;
    assign data_out_1 = dout[0];
    assign data_out_2 = dout[1];
    assign data_out_3 = dout[2];
    assign data_out_4 = dout[3];

    always_comb begin
        push = '0;
        for (int k = 0; k < NCH; k++)
            push[k] = result_valid & in_range & (sel == 2'(k)) & ~blocked[k];
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        result_router_chan #(.DEPTH(DEPTH)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .push     (push[g]),
            .data_in  (result[31:0]),
            .ack      (ack[g]),
            .data_out (dout[g]),
            .done     (done[g]),
            .blocked  (blocked[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else
            err <= drop;
    end

`ifdef RESULT_ROUTER_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst)
            drop_q <= 8'h00;
        else if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'h01;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_result_router.sv
// Directed bench for result_router (BASE_ID=1, DEPTH=2) with hand-computed expectations.
// Drop-count expectations follow RESULT_ROUTER_DROP_CNT_EN.

module tb_result_router;
    logic        clk = 1'b0;
    logic        rst;
    logic        result_valid;
    logic [35:0] result;
    logic [31:0] data_out_1, data_out_2, data_out_3, data_out_4;
    logic        done_1, done_2, done_3, done_4;
    logic        ack_1, ack_2, ack_3, ack_4;
    logic        err;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int err_pulses;

`ifdef RESULT_ROUTER_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    result_router #(.BASE_ID(1), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result       (result),
        .data_out_1   (data_out_1),
        .data_out_2   (data_out_2),
        .data_out_3   (data_out_3),
        .data_out_4   (data_out_4),
        .done_1       (done_1),
        .done_2       (done_2),
        .done_3       (done_3),
        .done_4       (done_4),
        .ack_1        (ack_1),
        .ack_2        (ack_2),
        .ack_3        (ack_3),
        .ack_4        (ack_4),
        .err          (err),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        result_valid = 1'b0;
        {ack_4, ack_3, ack_2, ack_1} = 4'b0;
    endtask

    task automatic send(input logic [3:0] id, input logic [31:0] data);
        result_valid = 1'b1;
        result = {id, data};
        tick();
        idle();
    endtask

    task automatic pop(input int ch);
        {ack_4, ack_3, ack_2, ack_1} = 4'(1 << (ch - 1));
        tick();
        idle();
    endtask

    function automatic logic [3:0] dones();
        return {done_4, done_3, done_2, done_1};
    endfunction

    initial begin
        rst = 1'b1;
        result = '0;
        idle();
        tick();
        tick();
        chk("rst_done", 32'(dones()), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_dout1", data_out_1, 32'h0);
        chk("rst_dout4", data_out_4, 32'h0);
        rst = 1'b0;
        tick();

        // Single routing to channel 2
        send(4'h2, 32'hDEADBEEF);
        chk("route_done", 32'(dones()), 32'h2);
        chk("route_data", data_out_2, 32'hDEADBEEF);
        chk("route_err", 32'(err), 32'h0);
        pop(2);
        chk("route_pop", 32'(done_2), 32'h0);
        chk("route_hold", data_out_2, 32'hDEADBEEF);

        // Ordering and pointer wrap on channel 1
        for (int i = 0; i < 3; i++) begin
            send(4'h1, 32'h11);
            chk("ord_err_a", 32'(err), 32'h0);
            send(4'h1, 32'h22);
            chk("ord_err_b", 32'(err), 32'h0);
            chk("ord_first", data_out_1, 32'h11);
            pop(1);
            chk("ord_second", data_out_1, 32'h22);
            chk("ord_done_mid", 32'(done_1), 32'h1);
            pop(1);
            chk("ord_empty", 32'(done_1), 32'h0);
        end

        // Ack on an empty channel is ignored
        pop(1);
        chk("empty_ack", 32'(done_1), 32'h0);
        send(4'h1, 32'h77);
        chk("empty_ack_data", data_out_1, 32'h77);
        pop(1);
        chk("empty_ack_pop", 32'(done_1), 32'h0);

        // Full drop on channel 3
        send(4'h3, 32'hA);
        send(4'h3, 32'hB);
        chk("full_err_b", 32'(err), 32'h0);
        send(4'h3, 32'hC);
        chk("full_err", 32'(err), 32'h1);
        chk("full_cnt", 32'(drop_cnt), CNT_EN ? 32'd1 : 32'd0);
        tick();
        chk("full_err_once", 32'(err), 32'h0);
        chk("full_head", data_out_3, 32'hA);
        pop(3);
        chk("full_pop_b", data_out_3, 32'hB);
        pop(3);
        chk("full_drained", 32'(done_3), 32'h0);

        // Full channel 4 with simultaneous push and pop
        send(4'h4, 32'h1);
        send(4'h4, 32'h2);
        result_valid = 1'b1;
        result = {4'h4, 32'h3};
        ack_4 = 1'b1;
        tick();
        idle();
        chk("sim_err", 32'(err), 32'h0);
        chk("sim_head", data_out_4, 32'h2);
        pop(4);
        chk("sim_next", data_out_4, 32'h3);
        chk("sim_occ", 32'(done_4), 32'h1);
        pop(4);
        chk("sim_empty", 32'(done_4), 32'h0);

        // Bad ID flood saturates the counter
        err_pulses = 0;
        result_valid = 1'b1;
        result = {4'h0, 32'h12345678};
        for (int i = 0; i < 300; i++) begin
            tick();
            if (err) err_pulses++;
        end
        idle();
        chk("bad_pulses", 32'(err_pulses), 32'd300);
        chk("bad_cnt", 32'(drop_cnt), CNT_EN ? 32'd255 : 32'd0);
        chk("bad_done", 32'(dones()), 32'h0);
        tick();
        chk("bad_err_end", 32'(err), 32'h0);

        // Reset mid-operation with a coincident result
        send(4'h1, 32'h101);
        send(4'h2, 32'h202);
        send(4'h3, 32'h303);
        send(4'h4, 32'h404);
        chk("mid_full", 32'(dones()), 32'hF);
        rst = 1'b1;
        result_valid = 1'b1;
        result = {4'h1, 32'h55};
        tick();
        rst = 1'b0;
        idle();
        chk("mid_done", 32'(dones()), 32'h0);
        chk("mid_drop", 32'(drop_cnt), 32'h0);
        chk("mid_err", 32'(err), 32'h0);
        chk("mid_dout1", data_out_1, 32'h0);
        chk("mid_dout2", data_out_2, 32'h0);
        chk("mid_dout3", data_out_3, 32'h0);
        chk("mid_dout4", data_out_4, 32'h0);
        tick();
        chk("mid_nowrite", 32'(dones()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_router.md
RESULT_ROUTER -- requirements
Module: result_router

Interface
REQ-001 Parameter BASE_ID, default 1: request ID that maps to channel 1; channels 2..4 map to BASE_ID+1..BASE_ID+3.
REQ-002 Parameter DEPTH, default 2: entries per channel buffer; legal values 2 and 4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 result_valid  in  1  one-cycle strobe from the storage side; result is valid in that cycle.
REQ-006 result  in  36  returned read: bits [35:32] = requester ID, bits [31:0] = data word.
REQ-007 data_out_1..data_out_4  out  32 each  head-of-buffer data word per channel.
REQ-008 done_1..done_4  out  1 each  level signal; high while the channel buffer is non-empty.
REQ-009 ack_1..ack_4  in  1 each  consumer pop request for the channel.
REQ-010 err  out  1  one-cycle pulse on every dropped result.
REQ-011 drop_cnt  out  8  saturating count of dropped results.

Function
REQ-012 Each channel SHALL own an independent DEPTH-entry circular buffer with read pointer, write pointer and an occupancy counter of width clog2(DEPTH)+1.
REQ-013 On a result_valid cycle, ID in BASE_ID..BASE_ID+3, and a target buffer that is not full, the data word SHALL be written at the write pointer on that edge.
REQ-014 Latency: a word written on edge N SHALL appear on data_out_k with done_k high after edge N (visible in cycle N+1) when the buffer was empty.
REQ-015 data_out_k SHALL always show the oldest entry; data order within a channel is strictly FIFO.
REQ-016 ack_k with done_k high SHALL pop one entry on that edge; ack_k with done_k low SHALL be ignored with no pointer or count change.
REQ-017 Simultaneous push and pop on the same channel SHALL both take effect with the occupancy unchanged, including when the buffer is full (the push is accepted, not dropped).
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 A result SHALL be dropped when its ID is outside BASE_ID..BASE_ID+3, or when the target buffer is full and no same-cycle pop occurs.
REQ-020 A dropped result SHALL assert err in cycle N+1, leave all buffers unchanged, and increment drop_cnt, which saturates at 255.
REQ-021 When the buffer is empty, data_out_k SHALL hold its last value; consumers qualify it with done_k only.
REQ-022 Channels SHALL be fully independent; activity on one channel SHALL NOT stall or alter any other channel.

Reset
REQ-023 While rst is high at a clock edge, all pointers and counts SHALL clear to 0.
REQ-024 While rst is high at a clock edge, done_1..4, err and drop_cnt SHALL be 0 and data_out_1..4 SHALL be 32'h0.
REQ-025 A result_valid coinciding with rst high SHALL be discarded and SHALL NOT be counted.
REQ-026 Buffered entries present when rst asserts mid-operation SHALL be lost.

Configuration
REQ-027 When the macro RESULT_ROUTER_DROP_CNT_EN is defined, the drop_cnt counter SHALL be implemented as specified in REQ-020.
REQ-028 When RESULT_ROUTER_DROP_CNT_EN is undefined, drop_cnt SHALL be tied to 8'h00, no counter flops SHALL exist, and err SHALL still pulse on every drop.

Verification
REQ-029 Single routing: result 36'h2_DEADBEEF with result_valid for one cycle, BASE_ID=1 -> next cycle done_2=1, data_out_2=32'hDEADBEEF, other done low; ack_2 for one cycle -> done_2=0.
REQ-030 Ordering and wrap: for ID 1, push 32'h11, 32'h22 and then pop both, repeated 3 times (DEPTH=2) -> data_out_1 sequence 11,22,11,22,11,22 with no err.
REQ-031 Full drop: push 3 results to ID 3 (32'hA, 32'hB, 32'hC) with no ack, DEPTH=2 -> err pulses once after the third, drop_cnt=1, and pops yield A then B.
REQ-032 Full with simultaneous pop: channel 4 full (32'h1, 32'h2); ack_4 asserted in the same cycle as a push of 32'h3 -> no err, occupancy stays 2, and subsequent pops yield 2 then 3.
REQ-033 Bad ID and saturation: 300 results with ID 4'h0 -> err 300 pulses, drop_cnt=255 with the macro defined and 0 without it, all done low.
REQ-034 Reset mid-operation: all four channels hold 1 entry; rst high for 1 cycle while result_valid is high -> afterwards all done low, drop_cnt=0, data_out all 0, and no entry was written.
